// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/write-back.
// Optional feature macro: MULTICYCLE_ADDI_EN enables the ADDIEX/ADDIWB path for opcode 001000.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       MemBusy,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] AluOp,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
`ifdef MULTICYCLE_ADDI_EN
    , ADDIEX = 4'd10,
    ADDIWB = 4'd11
`endif
  } state_t;

  state_t state_r;
  logic   illegal_r;

  // State register and sticky illegal-opcode flag; memory states hold while MemBusy is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FETCH;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        FETCH:   if (!MemBusy) state_r <= DECODE;
        DECODE: begin
          case (Op)
            6'b000000:           state_r <= EXEC;
            6'b100011, 6'b101011: state_r <= MEMADR;
            6'b000100:           state_r <= BRANCH;
            6'b000010:           state_r <= JUMP;
`ifdef MULTICYCLE_ADDI_EN
            6'b001000:           state_r <= ADDIEX;
`endif
            default: begin
              state_r   <= FETCH;
              illegal_r <= 1'b1;
            end
          endcase
        end
        MEMADR:  state_r <= (Op == 6'b100011) ? MEMRD : MEMWR;
        MEMRD:   if (!MemBusy) state_r <= MEMWB;
        MEMWR:   if (!MemBusy) state_r <= FETCH;
        EXEC:    state_r <= RWB;
`ifdef MULTICYCLE_ADDI_EN
        ADDIEX:  state_r <= ADDIWB;
`endif
        default: state_r <= FETCH;
      endcase
    end
  end

  // Moore output decode; PC/IR update and completion are suppressed while memory stalls.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    AluOp       = 2'b00;
    InstrDone   = 1'b0;
    case (state_r)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = !MemBusy;
        PCWrite = !MemBusy;
        ALUSrcB = 2'b01;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = !MemBusy;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        AluOp   = 2'b10;
      end
      RWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        AluOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        InstrDone   = 1'b1;
      end
      JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        InstrDone = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
`endif
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

  assign State     = state_r;
  assign IllegalOp = illegal_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction phase sequences are generated from the
// instruction class, and one negedge process compares the DUT against them every cycle.
module tb_multicycle_control;

  logic       clk, rst_n;
  logic [5:0] Op;
  logic       MemBusy;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       RegWrite, RegDst, ALUSrcA, InstrDone, IllegalOp;
  logic [1:0] ALUSrcB, PCSource, AluOp;
  logic [3:0] State;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  logic       exp_valid = 1'b0;
  logic [3:0] exp_state;
  logic       exp_busy;
  logic       exp_ill;
  logic       ill_m = 1'b0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .MemBusy(MemBusy),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .AluOp(AluOp), .InstrDone(InstrDone), .IllegalOp(IllegalOp), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Control word for a phase, taken from the per-state output table.
  function automatic logic [16:0] exp_outs(input logic [3:0] st, input logic busy);
    logic pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa, id;
    logic [1:0] asb, pcs, aop;
    {pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa, id} = 11'b0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (st)
      4'd0: begin mr = 1'b1; irw = !busy; pcw = !busy; asb = 2'b01; end
      4'd1: asb = 2'b11;
      4'd2: begin asa = 1'b1; asb = 2'b10; end
      4'd3: begin mr = 1'b1; iord = 1'b1; end
      4'd4: begin rw = 1'b1; m2r = 1'b1; id = 1'b1; end
      4'd5: begin mw = 1'b1; iord = 1'b1; id = !busy; end
      4'd6: begin asa = 1'b1; aop = 2'b10; end
      4'd7: begin rw = 1'b1; rd = 1'b1; id = 1'b1; end
      4'd8: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; id = 1'b1; end
      4'd9: begin pcw = 1'b1; pcs = 2'b10; id = 1'b1; end
`ifdef MULTICYCLE_ADDI_EN
      4'd10: begin asa = 1'b1; asb = 2'b10; end
      4'd11: begin rw = 1'b1; id = 1'b1; end
`endif
      default: pcw = 1'b0;
    endcase
    return {pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa, asb, pcs, aop, id};
  endfunction

  function automatic logic [16:0] dut_outs();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
            RegDst, ALUSrcA, ALUSrcB, PCSource, AluOp, InstrDone};
  endfunction

  // Per-cycle comparison against the expected phase.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("state", 32'(State), 32'(exp_state));
      check("outputs", 32'(dut_outs()), 32'(exp_outs(exp_state, exp_busy)));
      check("illegal", 32'(IllegalOp), 32'(exp_ill));
      if (InstrDone) done_cnt++;
    end
  end

  task automatic step(input logic [5:0] op, input logic busy, input logic [3:0] st);
    Op = op; MemBusy = busy;
    exp_state = st; exp_busy = busy; exp_ill = ill_m; exp_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  // Expands one instruction into its phase sequence; returns its cycle count.
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                           output int n);
    n = 0;
    repeat (fstall) begin step(6'($urandom), 1'b1, 4'd0); n++; end
    step(6'($urandom), 1'b0, 4'd0); n++;
    step(op, 1'b0, 4'd1); n++;
    case (op)
      6'b000000: begin step(op, 1'b0, 4'd6); step(op, 1'b0, 4'd7); n += 2; end
      6'b100011: begin
        step(op, 1'b0, 4'd2); n++;
        repeat (mstall) begin step(op, 1'b1, 4'd3); n++; end
        step(op, 1'b0, 4'd3); step(op, 1'b0, 4'd4); n += 2;
      end
      6'b101011: begin
        step(op, 1'b0, 4'd2); n++;
        repeat (mstall) begin step(op, 1'b1, 4'd5); n++; end
        step(op, 1'b0, 4'd5); n++;
      end
      6'b000100: begin step(op, 1'b0, 4'd8); n++; end
      6'b000010: begin step(op, 1'b0, 4'd9); n++; end
`ifdef MULTICYCLE_ADDI_EN
      6'b001000: begin step(op, 1'b0, 4'd10); step(op, 1'b0, 4'd11); n += 2; end
`endif
      default: ill_m = 1'b1;
    endcase
  endtask

  initial begin
    int n, d0;
    rst_n = 1'b0; Op = 6'b0; MemBusy = 1'b0;
    #2;
    check("rst_state", 32'(State), 32'd0);
    check("rst_illegal", 32'(IllegalOp), 32'd0);
    check("rst_pcwrite", 32'(PCWrite), 32'd1);
    check("rst_outs", 32'(dut_outs()), 32'(exp_outs(4'd0, 1'b0)));
    MemBusy = 1'b1; #1;
    check("rst_busy_pcwrite", 32'(PCWrite), 32'd0);
    check("rst_busy_memread", 32'(MemRead), 32'd1);
    MemBusy = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;

    d0 = done_cnt; run_instr(6'b000000, 0, 0, n);
    check("rtype_cycles", 32'(n), 32'd4); check("rtype_done", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt; run_instr(6'b100011, 0, 2, n);
    check("lw_stall_cycles", 32'(n), 32'd7); check("lw_stall_done", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt; run_instr(6'b100011, 0, 0, n);
    check("lw_cycles", 32'(n), 32'd5); check("lw_done", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt; run_instr(6'b101011, 0, 1, n);
    check("sw_cycles", 32'(n), 32'd5); check("sw_done", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt; run_instr(6'b000100, 0, 0, n);
    check("beq_cycles", 32'(n), 32'd3); check("beq_done", 32'(done_cnt - d0), 32'd1);

    d0 = done_cnt; run_instr(6'b001000, 3, 0, n);
`ifdef MULTICYCLE_ADDI_EN
    check("addi_cycles", 32'(n), 32'd7); check("addi_done", 32'(done_cnt - d0), 32'd1);
    check("addi_illegal", 32'(IllegalOp), 32'd0);
`else
    check("addi_cycles", 32'(n), 32'd5); check("addi_done", 32'(done_cnt - d0), 32'd0);
    check("addi_illegal", 32'(IllegalOp), 32'd1);
`endif

    // Reset asserted in the middle of EXEC.
    step(6'b000000, 1'b0, 4'd0);
    step(6'b000000, 1'b0, 4'd1);
    Op = 6'b000000; MemBusy = 1'b0;
    exp_state = 4'd6; exp_busy = 1'b0; exp_ill = ill_m;
    @(negedge clk); #2;
    exp_valid = 1'b0; rst_n = 1'b0; ill_m = 1'b0;
    #1;
    check("midrst_state", 32'(State), 32'd0);
    check("midrst_regwrite", 32'(RegWrite), 32'd0);
    @(posedge clk); #1;
    check("midrst_edge_state", 32'(State), 32'd0);
    check("midrst_memread", 32'(MemRead), 32'd1);
    check("midrst_irwrite", 32'(IRWrite), 32'd1);
    check("midrst_pcwrite", 32'(PCWrite), 32'd1);
    check("midrst_aluop", 32'(AluOp), 32'd0);
    check("midrst_illegal", 32'(IllegalOp), 32'd0);
    rst_n = 1'b1;

    d0 = done_cnt; run_instr(6'b111111, 0, 0, n);
    check("illegal_cycles", 32'(n), 32'd2); check("illegal_done", 32'(done_cnt - d0), 32'd0);
    check("illegal_flag", 32'(IllegalOp), 32'd1);
    d0 = done_cnt; run_instr(6'b000010, 0, 0, n);
    check("j_cycles", 32'(n), 32'd3); check("j_done", 32'(done_cnt - d0), 32'd1);
    check("j_illegal_sticky", 32'(IllegalOp), 32'd1);
    step(6'b000000, 1'b0, 4'd0);
    exp_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
